// File: rtl/riscv_pkg.sv
// riscv_pkg: shared parcel type and instruction-length constants for the fetch aligner
package riscv_pkg;
  typedef logic [15:0] parcel_t;
  localparam logic [1:0] OPC_FULL = 2'b11;
  localparam int PARCEL_BYTES = 2;
endpackage

// File: rtl/riscv_falign_buf.sv
// riscv_falign_buf: circular parcel buffer with 0/1/2-parcel push and pop, exposing two head entries
module riscv_falign_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  parcel_t       push_d0,
  input  parcel_t       push_d1,
  input  logic [1:0]    pop_n,
  output parcel_t       head0,
  output parcel_t       head1,
  output logic [CW-1:0] count
);
  parcel_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign head0 = mem[rd];
  assign head1 = mem[rd + PW'(1)];
  // pointer and occupancy bookkeeping; flush empties the buffer and wins over push/pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd + PW'(pop_n);
      wr    <= wr + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  // parcel storage; contents are meaningless until counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) mem[wr] <= push_d0;
    if (!flush && push_n == 2'd2) mem[wr + PW'(1)] <= push_d1;
  end
endmodule

// File: rtl/riscv_falign.sv
// riscv_falign: splits fetch words into parcels and reassembles RV64IMC instructions with PC
module riscv_falign
  import riscv_pkg::*;
#(
  parameter int               width   = 64,
  parameter int               DEPTH   = 4,
  parameter logic [width-1:0] RESETPC = '0
) (
  input  logic             i_riscv_falign_clk,
  input  logic             i_riscv_falign_rst,
  input  logic             i_riscv_falign_wvalid,
  input  logic [31:0]      i_riscv_falign_wdata,
  output logic             o_riscv_falign_wready,
  input  logic             i_riscv_falign_flush,
  input  logic [width-1:0] i_riscv_falign_target,
  output logic             o_riscv_falign_ivalid,
  input  logic             i_riscv_falign_iready,
  output logic [31:0]      o_riscv_falign_inst,
  output logic [width-1:0] o_riscv_falign_pc,
  output logic             o_riscv_falign_compressed
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [width-1:0] head_pc;
  logic             skip, c, push, pop;
  logic [1:0]       push_n, pop_n;
  logic [CW-1:0]    count;
  parcel_t          head0, head1;

  riscv_falign_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (i_riscv_falign_clk),
    .rst_n   (i_riscv_falign_rst),
    .flush   (i_riscv_falign_flush),
    .push_n  (push_n),
    .push_d0 (skip ? i_riscv_falign_wdata[31:16] : i_riscv_falign_wdata[15:0]),
    .push_d1 (i_riscv_falign_wdata[31:16]),
    .pop_n   (pop_n),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

  // head decode, handshakes and parcel counts; outputs are gated to zero when nothing is presented
  always_comb begin
    c                         = head0[1:0] != OPC_FULL;
    o_riscv_falign_ivalid     = (count != '0 && c) || (count >= CW'(2) && !c);
    o_riscv_falign_wready     = (count <= CW'(DEPTH - 2)) || (skip && count < CW'(DEPTH));
    o_riscv_falign_inst       = !o_riscv_falign_ivalid ? 32'h0 : c ? {16'h0, head0} : {head1, head0};
    o_riscv_falign_compressed = o_riscv_falign_ivalid && c;
    o_riscv_falign_pc         = head_pc;
    push                      = i_riscv_falign_wvalid && o_riscv_falign_wready && !i_riscv_falign_flush;
    pop                       = o_riscv_falign_ivalid && i_riscv_falign_iready && !i_riscv_falign_flush;
    push_n                    = !push ? 2'd0 : skip ? 2'd1 : 2'd2;
    pop_n                     = !pop ? 2'd0 : c ? 2'd1 : 2'd2;
  end

  // head PC advance and redirect; skip drops the low parcel of the first word after a mid-word target
  always_ff @(posedge i_riscv_falign_clk or negedge i_riscv_falign_rst)
    if (!i_riscv_falign_rst) begin
      head_pc <= RESETPC;
      skip    <= 1'b0;
    end else if (i_riscv_falign_flush) begin
      head_pc <= i_riscv_falign_target;
      skip    <= i_riscv_falign_target[1];
    end else begin
      if (pop) head_pc <= head_pc + (c ? width'(PARCEL_BYTES) : width'(2 * PARCEL_BYTES));
      if (push) skip <= 1'b0;
    end
endmodule

// File: tb/tb_riscv_falign.sv
// tb_riscv_falign: directed and random checks of the aligner against a parcel-queue model
module tb_riscv_falign;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        wvalid = 1'b0, flush = 1'b0, iready = 1'b0;
  logic [31:0] wdata = '0;
  logic [63:0] target = '0;
  logic        wready, ivalid, compressed;
  logic [31:0] inst;
  logic [63:0] pc;
  int checks = 0, failures = 0;
  logic [15:0] q[$];
  logic [63:0] mpc = '0;
  logic        mskip = 1'b0;

  riscv_falign #(.width(64), .DEPTH(DEPTH), .RESETPC(64'h0)) dut (
    .i_riscv_falign_clk        (clk),
    .i_riscv_falign_rst        (rst),
    .i_riscv_falign_wvalid     (wvalid),
    .i_riscv_falign_wdata      (wdata),
    .o_riscv_falign_wready     (wready),
    .i_riscv_falign_flush      (flush),
    .i_riscv_falign_target     (target),
    .o_riscv_falign_ivalid     (ivalid),
    .i_riscv_falign_iready     (iready),
    .o_riscv_falign_inst       (inst),
    .o_riscv_falign_pc         (pc),
    .o_riscv_falign_compressed (compressed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_c();
    return q.size() > 0 && q[0][1:0] != 2'b11;
  endfunction

  function automatic logic m_ivalid();
    return q.size() >= 1 && (q[0][1:0] != 2'b11 || q.size() >= 2);
  endfunction

  function automatic logic m_wready();
    return (DEPTH - q.size() >= 2) || (mskip && q.size() < DEPTH);
  endfunction

  task automatic m_reset();
    q.delete();
    mpc = 64'h0;
    mskip = 1'b0;
  endtask

  task automatic cmp_all(input string tag);
    logic v;
    v = m_ivalid();
    chk({tag, "_ivalid"}, 64'(ivalid), 64'(v));
    chk({tag, "_pc"}, pc, mpc);
    chk({tag, "_wready"}, 64'(wready), 64'(m_wready()));
    if (v) begin
      chk({tag, "_inst"}, 64'(inst), m_c() ? {48'h0, q[0]} : {32'h0, q[1], q[0]});
      chk({tag, "_comp"}, 64'(compressed), 64'(m_c()));
    end
  endtask

  // one clock: drive, compare at the falling edge, advance the model, return just after the rising edge
  task automatic cyc(input logic wv, input logic [31:0] wd, input logic fl, input logic [63:0] tg, input logic rdy, input string tag);
    logic v, c, wr;
    wvalid = wv; wdata = wd; flush = fl; target = tg; iready = rdy;
    @(negedge clk);
    cmp_all(tag);
    v = m_ivalid(); c = m_c(); wr = m_wready();
    if (fl) begin
      q.delete();
      mpc = tg;
      mskip = tg[1];
    end else begin
      if (v && rdy) begin
        void'(q.pop_front());
        if (!c) void'(q.pop_front());
        mpc += c ? 64'd2 : 64'd4;
      end
      if (wv && wr) begin
        if (!mskip) q.push_back(wd[15:0]);
        q.push_back(wd[31:16]);
        mskip = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ivalid", 64'(ivalid), 64'h0);
    chk("rst_inst", 64'(inst), 64'h0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_comp", 64'(compressed), 64'h0);
    chk("rst_wready", 64'(wready), 64'h1);
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    // 1: single 32-bit instruction
    cyc(1, 32'h00A0_0513, 0, 0, 1, "t1_push");
    chk("t1_inst", 64'(inst), 64'h00A0_0513);
    chk("t1_comp", 64'(compressed), 64'h0);
    // 2: two compressed instructions in one word
    cyc(1, 32'h4505_4501, 0, 0, 1, "t2_push");
    chk("t2_inst0", 64'(inst), 64'h4501);
    chk("t2_pc0", pc, 64'h4);
    cyc(0, 0, 0, 0, 1, "t2_a");
    chk("t2_inst1", 64'(inst), 64'h4505);
    chk("t2_pc1", pc, 64'h6);
    cyc(0, 0, 0, 0, 1, "t2_b");
    // 3: 32-bit instruction straddling two words
    cyc(1, 32'h0513_4501, 0, 0, 1, "t3_w0");
    cyc(0, 0, 0, 0, 1, "t3_c");
    cyc(0, 0, 0, 0, 1, "t3_wait");
    chk("t3_half_ivalid", 64'(ivalid), 64'h0);
    cyc(1, 32'hBEEF_00A0, 0, 0, 1, "t3_w1");
    chk("t3_inst", 64'(inst), 64'h00A0_0513);
    cyc(0, 0, 0, 0, 1, "t3_drain");
    // 4: flush to a mid-word target while presenting and pushing
    cyc(1, 32'h4505_4501, 0, 0, 0, "t4_fill");
    cyc(1, 32'h1111_2222, 1, 64'h102, 1, "t4_flush");
    chk("t4_pc", pc, 64'h102);
    chk("t4_ivalid", 64'(ivalid), 64'h0);
    cyc(1, 32'h4505_9999, 0, 0, 0, "t4_push");
    chk("t4_inst", 64'(inst), 64'h4505);
    cyc(0, 0, 0, 0, 1, "t4_drain");
    // 5: fill with iready low, refused word, then drain
    cyc(1, 32'h0513_0513, 0, 0, 0, "t5_w0");
    cyc(1, 32'h4505_4501, 0, 0, 0, "t5_w1");
    chk("t5_full_wready", 64'(wready), 64'h0);
    cyc(1, 32'hFFFF_FFFF, 0, 0, 0, "t5_refused");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, "t5_drain");
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      logic [63:0] t;
      d = $urandom;
      if ($urandom_range(1, 0) == 1) d[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) d[17:16] = 2'b11;
      t = {$urandom, $urandom};
      t[0] = 1'b0;
      cyc($urandom_range(3, 0) != 0, d, $urandom_range(24, 0) == 0, t, $urandom_range(2, 0) != 0, "rnd");
    end
    // 6: asynchronous reset with three parcels held
    cyc(0, 0, 1, 64'h2, 0, "t6_flush");
    cyc(1, 32'h0513_4501, 0, 0, 0, "t6_w0");
    cyc(1, 32'h4505_4501, 0, 0, 0, "t6_w1");
    chk("t6_pre_ivalid", 64'(ivalid), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6_ivalid", 64'(ivalid), 64'h0);
    chk("t6_pc", pc, 64'h0);
    chk("t6_wready", 64'(wready), 64'h1);
    m_reset();
    @(posedge clk);
    #1;
    chk("t6_hold_ivalid", 64'(ivalid), 64'h0);
    chk("t6_hold_pc", pc, 64'h0);
    rst = 1'b1;
    cyc(1, 32'h4505_4501, 0, 0, 1, "t6_after");
    cyc(0, 0, 0, 0, 1, "t6_after2");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
